// File: rtl/xz_alu_pipe.sv
// Two-stage pipelined four-state ALU: operands and results are carried as value/unknown
// bit planes, and a saturating counter tracks delivered results that contain unknown bits.
module xz_alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_val,
  input  logic [WIDTH-1:0] a_unk,
  input  logic [WIDTH-1:0] b_val,
  input  logic [WIDTH-1:0] b_unk,
  input  logic             c_val,
  input  logic             c_unk,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_val,
  output logic [WIDTH-1:0] res_unk,
  output logic             bad_op,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] xcount
);

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_XOR  = 4'd2,  OP_XNOR = 4'd3,
    OP_NOT  = 4'd4,  OP_RAND = 4'd5,  OP_ROR  = 4'd6,  OP_RXOR = 4'd7,
    OP_SHL  = 4'd8,  OP_SHR  = 4'd9,  OP_ASHR = 4'd10, OP_EQ   = 4'd11,
    OP_CEQ  = 4'd12, OP_LAND = 4'd13, OP_MUX  = 4'd14, OP_RSVD = 4'd15
  } op_e;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] a_unk;
    logic [WIDTH-1:0] b_val;
    logic [WIDTH-1:0] b_unk;
    logic             c_val;
    logic             c_unk;
  } bundle_t;

  localparam logic [WIDTH-1:0] ONES = '1;

  logic             rdy_en_q, rdy_en_d;
  logic             s1_valid_q, s1_valid_d;
  bundle_t          s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_val_q, res_val_d;
  logic [WIDTH-1:0] res_unk_q, res_unk_d;
  logic             bad_op_q, bad_op_d;
  logic [CNT_W-1:0] xcount_q, xcount_d;

  logic s2_ready, s1_adv, in_xfer, out_xfer;

  // Known-0 / known-1 masks of the captured operands; z and x both count as unknown.
  logic [WIDTH-1:0] a_k0, a_k1, b_k0, b_k1, ab_unk;
  assign a_k0   = ~s1_q.a_unk & ~s1_q.a_val;
  assign a_k1   = ~s1_q.a_unk &  s1_q.a_val;
  assign b_k0   = ~s1_q.b_unk & ~s1_q.b_val;
  assign b_k1   = ~s1_q.b_unk &  s1_q.b_val;
  assign ab_unk =  s1_q.a_unk |  s1_q.b_unk;

  logic [WIDTH-1:0] alu_val, alu_unk;
  logic             alu_bad;
  logic             a_r0, a_rx, b_r0, b_rx, land0;
  logic             fill_v, fill_u;

  // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    alu_val = '0;
    alu_unk = '0;
    alu_bad = 1'b0;
    a_r0    = ~(|a_k1) & ~(|s1_q.a_unk);
    a_rx    = ~(|a_k1) &  (|s1_q.a_unk);
    b_r0    = ~(|b_k1) & ~(|s1_q.b_unk);
    b_rx    = ~(|b_k1) &  (|s1_q.b_unk);
    land0   = a_r0 | b_r0;
    fill_u  = s1_q.a_unk[WIDTH-1];
    fill_v  = s1_q.a_val[WIDTH-1] | s1_q.a_unk[WIDTH-1];
    case (op_e'(s1_q.op))
      OP_AND: begin
        alu_val = ~(a_k0 | b_k0);
        alu_unk = ~(a_k0 | b_k0) & ab_unk;
      end
      OP_OR: begin
        alu_val = a_k1 | b_k1 | ab_unk;
        alu_unk = ~(a_k1 | b_k1) & ab_unk;
      end
      OP_XOR: begin
        alu_val = ab_unk | (s1_q.a_val ^ s1_q.b_val);
        alu_unk = ab_unk;
      end
      OP_XNOR: begin
        alu_val = ab_unk | ~(s1_q.a_val ^ s1_q.b_val);
        alu_unk = ab_unk;
      end
      OP_NOT: begin
        alu_val = s1_q.a_unk | ~s1_q.a_val;
        alu_unk = s1_q.a_unk;
      end
      OP_RAND: begin
        alu_val[0] = ~(|a_k0);
        alu_unk[0] = ~(|a_k0) & (|s1_q.a_unk);
      end
      OP_ROR: begin
        alu_val[0] = (|a_k1) | (|s1_q.a_unk);
        alu_unk[0] = ~(|a_k1) & (|s1_q.a_unk);
      end
      OP_RXOR: begin
        alu_val[0] = (|s1_q.a_unk) | (^s1_q.a_val);
        alu_unk[0] = |s1_q.a_unk;
      end
      OP_SHL: begin
        alu_val = (|s1_q.b_unk) ? ONES : s1_q.a_val << s1_q.b_val;
        alu_unk = (|s1_q.b_unk) ? ONES : s1_q.a_unk << s1_q.b_val;
      end
      OP_SHR: begin
        alu_val = (|s1_q.b_unk) ? ONES : s1_q.a_val >> s1_q.b_val;
        alu_unk = (|s1_q.b_unk) ? ONES : s1_q.a_unk >> s1_q.b_val;
      end
      OP_ASHR: begin
        // Vacated upper bits take the sign pair; a z sign becomes x in the fill only.
        alu_val = (|s1_q.b_unk) ? ONES :
                  (s1_q.a_val >> s1_q.b_val) | ({WIDTH{fill_v}} & ~(ONES >> s1_q.b_val));
        alu_unk = (|s1_q.b_unk) ? ONES :
                  (s1_q.a_unk >> s1_q.b_val) | ({WIDTH{fill_u}} & ~(ONES >> s1_q.b_val));
      end
      OP_EQ: begin
        alu_val[0] = ~(|(a_k0 & b_k1 | a_k1 & b_k0));
        alu_unk[0] = ~(|(a_k0 & b_k1 | a_k1 & b_k0)) & (|ab_unk);
      end
      OP_CEQ: begin
        alu_val[0] = (s1_q.a_val == s1_q.b_val) && (s1_q.a_unk == s1_q.b_unk);
      end
      OP_LAND: begin
        alu_val[0] = ~land0;
        alu_unk[0] = ~land0 & (a_rx | b_rx);
      end
      OP_MUX: begin
        if (!s1_q.c_unk) begin
          alu_val = s1_q.c_val ? s1_q.a_val : s1_q.b_val;
          alu_unk = s1_q.c_val ? s1_q.a_unk : s1_q.b_unk;
        end else begin
          alu_unk = ab_unk | (s1_q.a_val ^ s1_q.b_val);
          alu_val = alu_unk | s1_q.a_val;
        end
      end
      default: begin
        alu_val = ONES;
        alu_unk = ONES;
        alu_bad = 1'b1;
      end
    endcase
  end

  assign s2_ready = ~s2_valid_q | out_ready;
  assign s1_adv   = s1_valid_q & s2_ready;
  assign in_ready = rdy_en_q & (~s1_valid_q | s2_ready);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = s2_valid_q & out_ready;

  always_comb begin
    rdy_en_d   = 1'b1;
    s1_valid_d = in_xfer | (s1_valid_q & ~s2_ready);
    s1_d       = s1_q;
    if (in_xfer) begin
      s1_d = '{op: op, a_val: a_val, a_unk: a_unk, b_val: b_val, b_unk: b_unk,
               c_val: c_val, c_unk: c_unk};
    end
    s2_valid_d = s1_adv | (s2_valid_q & ~out_ready);
    res_val_d  = s1_adv ? alu_val : res_val_q;
    res_unk_d  = s1_adv ? alu_unk : res_unk_q;
    bad_op_d   = s1_adv ? alu_bad : bad_op_q;
    xcount_d   = xcount_q;
    if (clr_cnt) begin
      xcount_d = '0;
    end else if (out_xfer && (|res_unk_q) && (xcount_q != {CNT_W{1'b1}})) begin
      xcount_d = xcount_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      res_val_q  <= '0;
      res_unk_q  <= '0;
      bad_op_q   <= 1'b0;
      xcount_q   <= '0;
    end else begin
      rdy_en_q   <= rdy_en_d;
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      res_val_q  <= res_val_d;
      res_unk_q  <= res_unk_d;
      bad_op_q   <= bad_op_d;
      xcount_q   <= xcount_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign res_val   = res_val_q;
  assign res_unk   = res_unk_q;
  assign bad_op    = bad_op_q;
  assign xcount    = xcount_q;

endmodule

// File: tb/tb_xz_alu_pipe.sv
// Directed bench for xz_alu_pipe at WIDTH=4 with a 3-bit counter so saturation is reachable.
module tb_xz_alu_pipe;
  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [3:0]    op;
  logic [W-1:0]  a_val, a_unk, b_val, b_unk;
  logic          c_val, c_unk;
  logic          out_valid, out_ready;
  logic [W-1:0]  res_val, res_unk;
  logic          bad_op, clr_cnt;
  logic [CW-1:0] xcount;

  xz_alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a_val(a_val), .a_unk(a_unk), .b_val(b_val), .b_unk(b_unk),
    .c_val(c_val), .c_unk(c_unk), .out_valid(out_valid), .out_ready(out_ready),
    .res_val(res_val), .res_unk(res_unk), .bad_op(bad_op),
    .clr_cnt(clr_cnt), .xcount(xcount)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] op, av, au, bv, bu;
    logic       cv, cu;
    logic [3:0] ev, eu;
    logic       bad;
  } vec_t;

  vec_t vecs[$];
  int   exp_x = 0;

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    in_valid = 1'b1; op = v.op;
    a_val = v.av; a_unk = v.au; b_val = v.bv; b_unk = v.bu; c_val = v.cv; c_unk = v.cu;
    check($sformatf("v%0d_in_ready", idx), in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check($sformatf("v%0d_early", idx), out_valid, 0);
    @(negedge clk);
    check($sformatf("v%0d_out_valid", idx), out_valid, 1);
    check($sformatf("v%0d_res_val", idx), res_val, v.ev);
    check($sformatf("v%0d_res_unk", idx), res_unk, v.eu);
    check($sformatf("v%0d_bad_op", idx), bad_op, v.bad);
    @(negedge clk);
    if (v.eu != 0 && exp_x < 7) exp_x++;
    check($sformatf("v%0d_xcount", idx), xcount, exp_x);
    check($sformatf("v%0d_drained", idx), out_valid, 0);
  endtask

  initial begin
    logic [3:0] exp_q[$];
    logic [3:0] stream_a [4];
    int sent, got, stale;
    bit saw_stall;

    rst_n = 1'b0; in_valid = 1'b0; op = '0; a_val = '0; a_unk = '0; b_val = '0; b_unk = '0;
    c_val = 1'b0; c_unk = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;

    // op, a_val, a_unk, b_val, b_unk, c_val, c_unk, exp_val, exp_unk, bad
    vecs.push_back('{4'd0,  4'b1001, 4'b0000, 4'b1001, 4'b1000, 1'b0, 1'b0, 4'b1001, 4'b1000, 1'b0});
    vecs.push_back('{4'd1,  4'b0101, 4'b0000, 4'b0010, 4'b0100, 1'b0, 1'b0, 4'b0111, 4'b0000, 1'b0});
    vecs.push_back('{4'd0,  4'b0011, 4'b0100, 4'b0111, 4'b0000, 1'b0, 1'b0, 4'b0111, 4'b0100, 1'b0});
    vecs.push_back('{4'd0,  4'b0110, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'd2,  4'b1100, 4'b0000, 4'b1010, 4'b0001, 1'b0, 1'b0, 4'b0111, 4'b0001, 1'b0});
    vecs.push_back('{4'd3,  4'b1100, 4'b0000, 4'b1010, 4'b0000, 1'b0, 1'b0, 4'b1001, 4'b0000, 1'b0});
    vecs.push_back('{4'd4,  4'b1001, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0110, 4'b0010, 1'b0});
    vecs.push_back('{4'd5,  4'b1111, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0});
    vecs.push_back('{4'd5,  4'b1101, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'd6,  4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0});
    vecs.push_back('{4'd7,  4'b1011, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0});
    vecs.push_back('{4'd9,  4'b1001, 4'b0010, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0001, 1'b0});
    vecs.push_back('{4'd8,  4'b0011, 4'b0100, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0110, 4'b1000, 1'b0});
    vecs.push_back('{4'd8,  4'b1111, 4'b0000, 4'b0101, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'd9,  4'b1111, 4'b0000, 4'b0010, 4'b0010, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0});
    vecs.push_back('{4'd10, 4'b0010, 4'b1000, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b1100, 4'b1110, 1'b0});
    vecs.push_back('{4'd10, 4'b1000, 4'b0000, 4'b0111, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0});
    vecs.push_back('{4'd11, 4'b1101, 4'b0100, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'd11, 4'b1101, 4'b0100, 4'b1001, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0});
    vecs.push_back('{4'd11, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0});
    vecs.push_back('{4'd12, 4'b1011, 4'b1010, 4'b1001, 4'b1000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'd12, 4'b0011, 4'b1010, 4'b0011, 4'b1010, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0});
    vecs.push_back('{4'd12, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'd13, 4'b0100, 4'b0100, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0});
    vecs.push_back('{4'd13, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'd13, 4'b0100, 4'b0000, 4'b0001, 4'b1000, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0});
    vecs.push_back('{4'd14, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0});
    vecs.push_back('{4'd14, 4'b1111, 4'b0000, 4'b0001, 4'b1000, 1'b0, 1'b0, 4'b0001, 4'b1000, 1'b0});
    vecs.push_back('{4'd14, 4'b1100, 4'b1010, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1100, 4'b1010, 1'b0});
    vecs.push_back('{4'd14, 4'b0101, 4'b1000, 4'b0101, 4'b1000, 1'b1, 1'b1, 4'b1101, 4'b1000, 1'b0});
    vecs.push_back('{4'd15, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1});

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_res_val", res_val, 0);
    check("rst_res_unk", res_unk, 0);
    check("rst_bad_op", bad_op, 0);
    check("rst_xcount", xcount, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Saturated counter, unknown result and clear in the same transfer cycle
    @(negedge clk);
    in_valid = 1'b1; op = 4'd15;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("sat_out_valid", out_valid, 1);
    check("sat_xcount", xcount, 7);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("clr_xcount", xcount, 0);

    // Back-to-back stream with a consumer stall
    stream_a[0] = 4'h3; stream_a[1] = 4'h5; stream_a[2] = 4'hA; stream_a[3] = 4'hC;
    sent = 0; got = 0; saw_stall = 1'b0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 4) begin
        in_valid = 1'b1; op = 4'd2;
        a_val = stream_a[sent]; a_unk = '0; b_val = '0; b_unk = '0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check($sformatf("stream_extra_c%0d", cyc), 1, 0);
        end else begin
          check($sformatf("stream_val_c%0d", cyc), res_val, exp_q[0]);
          check($sformatf("stream_unk_c%0d", cyc), res_unk, 0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (in_valid && in_ready) begin
        exp_q.push_back(stream_a[sent]);
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_delivered", got, 4);
    check("stream_stall_seen", saw_stall, 1);
    check("stream_xcount", xcount, 0);

    // Reset with two bundles in flight
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = 4'd2; a_val = 4'h6;
    @(negedge clk);
    a_val = 4'h9;
    @(negedge clk);
    in_valid = 1'b0;
    check("midrst_pre_out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_res_val", res_val, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_release_in_ready", in_ready, 1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("midrst_no_stale", stale, 0);
    check("midrst_xcount", xcount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xz_alu_pipe.md
XZ_ALU_PIPE -- requirements
Module: xz_alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have parameter CNT_W, default 16, width of the unknown-result counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand bundle valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a bundle this cycle.
REQ-007 SHALL have port op  input  4  opcode, per REQ-016.
REQ-008 SHALL have ports a_val, a_unk, b_val, b_unk  input  WIDTH  four-state operands A, B as value/unknown planes.
REQ-009 SHALL have ports c_val, c_unk  input  1  four-state condition for MUX.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have ports res_val, res_unk  output  WIDTH  four-state result planes.
REQ-013 SHALL have port bad_op  output  1  result came from a reserved opcode.
REQ-014 SHALL have port clr_cnt  input  1  synchronous clear of xcount.
REQ-015 SHALL have port xcount  output  CNT_W  saturating count of delivered results with any unknown bit.

Function
REQ-016 Opcodes SHALL be: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NOT A, 5 RAND A, 6 ROR A, 7 RXOR A, 8 SHL A by B, 9 SHR, 10 ASHR, 11 EQ (==), 12 CEQ (===), 13 LAND (&&), 14 MUX (C ? A : B), 15 reserved.
REQ-017 Per-bit encoding SHALL be (unk,val): 00=0, 01=1, 10=z, 11=x.
REQ-018 All operators except shifts, CEQ and MUX data paths SHALL treat z inputs as x; produced unknowns SHALL be x (11).
REQ-019 AND/OR SHALL yield known dominant value when either input bit is known 0/1 respectively, otherwise x if any input unknown; XOR/XNOR/NOT SHALL yield x whenever any input bit is unknown.
REQ-020 Reductions, EQ, CEQ, LAND SHALL place a 1-bit result in bit 0; bits WIDTH-1..1 SHALL be known 0.
REQ-021 RAND: 0 if any known 0, else x if any unknown, else 1; ROR dual; RXOR: x if any unknown.
REQ-022 EQ: 0 if any bit position has both known and different, else x if any unknown, else 1; CEQ SHALL compare both planes exactly (z differs from x) and is always known.
REQ-023 LAND: each operand reduced as ROR; 0 if either is known 0, else x if either is x, else 1.
REQ-024 Shifts SHALL move both planes unchanged (z preserved); SHL/SHR fill known 0; ASHR fills with A's MSB pair (z fill treated as x).
REQ-025 Shift amount B SHALL be unsigned; any unknown bit in B SHALL give all-x result; amount >= WIDTH SHALL give full fill.
REQ-026 MUX with known C SHALL pass the selected operand unchanged, including z; with unknown C each bit SHALL be the common value where A and B agree and are known, else x.
REQ-027 Opcode 15 SHALL give all-x result with bad_op=1; bad_op=0 for all other opcodes.
REQ-028 Pipeline SHALL be two register stages (capture, result); an accepted bundle SHALL appear at out_valid exactly 2 cycles after acceptance when out_ready stays high.
REQ-029 Transfer occurs on in_valid && in_ready; in_ready SHALL be 1 when stage 1 is empty or advancing this cycle; full throughput of one bundle per cycle with out_ready=1.
REQ-030 While out_valid && !out_ready, res_val, res_unk, bad_op SHALL hold stable and no bundle may be lost or duplicated (max 2 in flight).
REQ-031 xcount SHALL increment on each output transfer (out_valid && out_ready) whose res_unk != 0, saturating at all-ones.
REQ-032 clr_cnt SHALL zero xcount next edge; clr_cnt coincident with an incrementing transfer SHALL yield 0.

Reset
REQ-033 rst_n low SHALL asynchronously clear both stage valids, out_valid=0, in_ready=0 while asserted, res_val=0, res_unk=0, bad_op=0, xcount=0.
REQ-034 in_ready SHALL be 1 on the first edge after rst_n deasserts; in-flight bundles at reset SHALL be discarded without output.

Verification (WIDTH=4)
REQ-035 AND A=1001/0000, B val 1001 unk 1000 (x001), out_ready=1 -> 2 cycles later res val 1001 unk 1000, xcount=1.
REQ-036 SHR A val 1001 unk 0010 (10z1), B=0001 -> res val 0100 unk 0001 (010z); CEQ x0x1 vs x001 -> res 0000 known.
REQ-037 MUX C=z, A=0001, B=0000 -> res bit0 x, bits3..1 known 0; MUX C=0, B=z001 -> res z001 unchanged.
REQ-038 Stream 4 bundles back-to-back, out_ready low cycles 3-5 -> results in order, no loss, in_ready drops when both stages full.
REQ-039 op=15 -> all-x, bad_op=1; xcount at max with unknown result -> stays max; clr_cnt same cycle -> 0.
REQ-040 rst_n low mid-stream with 2 in flight -> out_valid=0 immediately, no stale result after release.
